ring_network_interface: RTL and testbench

- Endpoint between a processing element (PE) and the host port of one ring router.
- TX path: buffers PE packets in a FIFO and injects them into the router, with stall-retry and a minimum inter-injection gap.
- RX path: accepts ejected packets from the router, checks the destination, and buffers them for the PE.
- Self-addressed packets loop back locally and never enter the ring.

---
 rtl/ring_network_interface.sv | 140 ++++++++++++++
 tb/tb_ring_network_interface.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ring_network_interface.sv
// ring_network_interface: PE endpoint of a ring router with TX/RX FIFOs, stall-retry injection, gap timing and local loopback
module ring_network_interface #(
    parameter int NODE_ID     = 0,
    parameter int PACKET_SIZE = 8,
    parameter int ROUTER_BITS = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int INJ_GAP     = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PACKET_SIZE-1:0] pe_tx_data,
    input  logic                   pe_tx_valid,
    output logic                   pe_tx_ready,
    output logic [PACKET_SIZE-1:0] pe_rx_data,
    output logic                   pe_rx_valid,
    input  logic                   pe_rx_ready,
    output logic [PACKET_SIZE-1:0] inj_data,
    output logic                   inj_enable,
    input  logic                   inj_stall,
    input  logic [PACKET_SIZE-1:0] ej_data,
    input  logic                   ej_valid,
    output logic [CNT_WIDTH-1:0]   tx_count,
    output logic [CNT_WIDTH-1:0]   rx_count,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic [CNT_WIDTH-1:0]   misroute_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [ROUTER_BITS-1:0] ME = ROUTER_BITS'(NODE_ID);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t state, next_state;

    logic [PACKET_SIZE-1:0] tx_mem [FIFO_DEPTH];
    logic [PACKET_SIZE-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [AW:0] tx_cnt, rx_cnt;
    logic ready_en;
    logic [2:0] gap_cnt;
    logic [PACKET_SIZE-1:0] tx_head, rx_wdata;
    logic tx_empty, tx_full, rx_full, head_remote, head_local, gap_done;
    logic tx_push, tx_pop, rx_push, rx_pop, loopback, issue_done, ej_mine, ej_push;

    assign tx_head     = tx_mem[tx_rp];
    assign tx_empty    = tx_cnt == '0;
    assign tx_full     = tx_cnt == (AW+1)'(FIFO_DEPTH);
    assign rx_full     = rx_cnt == (AW+1)'(FIFO_DEPTH);
    assign head_remote = !tx_empty && tx_head[ROUTER_BITS-1:0] != ME;
    assign head_local  = !tx_empty && tx_head[ROUTER_BITS-1:0] == ME;
    assign gap_done    = gap_cnt == 3'(INJ_GAP - 1);
    // ready comes from registered occupancy only, and stays low until the first edge after reset
    assign pe_tx_ready = ready_en && !tx_full;
    assign pe_rx_valid = rx_cnt != '0;
    assign pe_rx_data  = pe_rx_valid ? rx_mem[rx_rp] : '0;
    assign tx_push     = pe_tx_valid && pe_tx_ready;
    assign rx_pop      = pe_rx_valid && pe_rx_ready;
    assign ej_mine     = ej_data[ROUTER_BITS-1:0] == ME;
    assign ej_push     = ej_valid && ej_mine && (!rx_full || rx_pop);
    // ejection owns the RX write port; a self-addressed head only moves on a free, non-full cycle
    assign loopback    = state == IDLE && head_local && !ej_valid && (!rx_full || rx_pop);
    assign issue_done  = state == ISSUE && !inj_stall;
    assign tx_pop      = loopback || issue_done;
    assign rx_push     = ej_push || loopback;
    assign rx_wdata    = ej_valid ? ej_data : tx_head;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // FSM next state; an expiring gap launches the next remote packet directly so the gap is exact
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = head_remote ? ISSUE : IDLE;
            ISSUE:   next_state = inj_stall ? ISSUE : (INJ_GAP > 0 ? GAP : IDLE);
            GAP:     next_state = gap_done ? (head_remote ? ISSUE : IDLE) : GAP;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        inj_enable = state == ISSUE;
    end

    // gap timer, injection data register and post-reset ready enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt  <= '0;
            inj_data <= '0;
            ready_en <= 1'b0;
        end else begin
            gap_cnt  <= state == GAP ? gap_cnt + 3'd1 : 3'd0;
            inj_data <= next_state == ISSUE ? tx_head : inj_data;
            ready_en <= 1'b1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            tx_wp  <= tx_push ? tx_wp + AW'(1) : tx_wp;
            tx_rp  <= tx_pop ? tx_rp + AW'(1) : tx_rp;
            tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            rx_wp  <= rx_push ? rx_wp + AW'(1) : rx_wp;
            rx_rp  <= rx_pop ? rx_rp + AW'(1) : rx_rp;
            rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= pe_tx_data;
        if (rx_push) rx_mem[rx_wp] <= rx_wdata;
    end

    // saturating statistics counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_count       <= '0;
            rx_count       <= '0;
            drop_count     <= '0;
            misroute_count <= '0;
        end else begin
            tx_count       <= tx_count + CNT_WIDTH'(tx_pop && tx_count != '1);
            rx_count       <= rx_count + CNT_WIDTH'(rx_push && rx_count != '1);
            drop_count     <= drop_count + CNT_WIDTH'(ej_valid && ej_mine && rx_full && !rx_pop && drop_count != '1);
            misroute_count <= misroute_count + CNT_WIDTH'(ej_valid && !ej_mine && misroute_count != '1);
        end
    end
endmodule

// File: tb/tb_ring_network_interface.sv
// tb_ring_network_interface: directed scoreboard bench for ring_network_interface with NODE_ID=1
module tb_ring_network_interface;
    logic clk = 0;
    logic rst = 0;
    logic [7:0] pe_tx_data = '0, pe_rx_data, inj_data, ej_data = '0;
    logic pe_tx_valid = 0, pe_tx_ready, pe_rx_valid, pe_rx_ready = 0;
    logic inj_enable, inj_stall = 0, ej_valid = 0;
    logic [7:0] tx_count, rx_count, drop_count, misroute_count;

    int total = 0;
    int bad = 0;
    int en_cycles = 0;
    logic [7:0] inj_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] pk [5];
    logic [7:0] e;

    ring_network_interface #(.NODE_ID(1), .PACKET_SIZE(8), .ROUTER_BITS(2), .FIFO_DEPTH(4), .INJ_GAP(1), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .pe_tx_data(pe_tx_data), .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready),
        .pe_rx_data(pe_rx_data), .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready),
        .inj_data(inj_data), .inj_enable(inj_enable), .inj_stall(inj_stall),
        .ej_data(ej_data), .ej_valid(ej_valid),
        .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count), .misroute_count(misroute_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mid-cycle: score handshakes against the queues, then advance one edge and settle
    task automatic tick();
        #4;
        if (inj_enable) en_cycles++;
        if (inj_enable && !inj_stall) begin
            if (inj_q.size() == 0) chk("inj_unexpected", 32'(inj_data), 32'hFFFF);
            else begin e = inj_q.pop_front(); chk("inj_pkt", 32'(inj_data), 32'(e)); end
        end
        if (pe_rx_valid && pe_rx_ready) begin
            if (rx_q.size() == 0) chk("rx_unexpected", 32'(pe_rx_data), 32'hFFFF);
            else begin e = rx_q.pop_front(); chk("rx_pkt", 32'(pe_rx_data), 32'(e)); end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        pk[0] = 8'h50; pk[1] = 8'h52; pk[2] = 8'h53; pk[3] = 8'h54; pk[4] = 8'h56;
        tick(); tick();
        chk("rst_inj_en", 32'(inj_enable), 0);
        chk("rst_inj_data", 32'(inj_data), 0);
        chk("rst_rx_valid", 32'(pe_rx_valid), 0);
        chk("rst_rx_data", 32'(pe_rx_data), 0);
        chk("rst_tx_ready", 32'(pe_tx_ready), 0);
        chk("rst_counters", {tx_count, rx_count, drop_count, misroute_count}, 0);
        rst = 1;
        chk("ready_before_edge", 32'(pe_tx_ready), 0);
        tick();
        chk("ready_after_edge", 32'(pe_tx_ready), 1);

        // basic injection latency and exact one-cycle gap
        pe_tx_data = 8'h43; pe_tx_valid = 1; inj_q.push_back(8'h43);
        tick();
        pe_tx_data = 8'h47; inj_q.push_back(8'h47);
        chk("lat_idle", 32'(inj_enable), 0);
        tick();
        pe_tx_valid = 0;
        chk("lat_en", 32'(inj_enable), 1);
        chk("lat_data", 32'(inj_data), 32'h43);
        tick();
        chk("gap_en", 32'(inj_enable), 0);
        chk("gap_txc", 32'(tx_count), 1);
        chk("gap_data_hold", 32'(inj_data), 32'h43);
        tick();
        chk("second_en", 32'(inj_enable), 1);
        chk("second_data", 32'(inj_data), 32'h47);
        tick(); tick();
        chk("two_txc", 32'(tx_count), 2);

        // stall retry for three cycles
        pe_tx_data = 8'h42; pe_tx_valid = 1; inj_q.push_back(8'h42);
        tick();
        pe_tx_valid = 0;
        tick();
        en_cycles = 0;
        inj_stall = 1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", 32'(inj_data), 32'h42);
            tick();
        end
        chk("stall_txc", 32'(tx_count), 2);
        inj_stall = 0;
        tick();
        chk("stall_en_cycles", 32'(en_cycles), 4);
        chk("stall_txc_done", 32'(tx_count), 3);
        tick();

        // fill TX FIFO under stall; fifth packet waits for the first injection
        inj_stall = 1;
        for (int i = 0; i < 4; i++) begin
            pe_tx_data = pk[i]; pe_tx_valid = 1;
            chk("fill_ready", 32'(pe_tx_ready), 1);
            inj_q.push_back(pk[i]);
            tick();
        end
        pe_tx_data = pk[4];
        chk("full_ready", 32'(pe_tx_ready), 0);
        tick(); tick();
        chk("full_ready_held", 32'(pe_tx_ready), 0);
        inj_stall = 0;
        tick();
        chk("ready_after_pop", 32'(pe_tx_ready), 1);
        inj_q.push_back(pk[4]);
        tick();
        pe_tx_valid = 0;
        for (int k = 0; k < 40 && inj_q.size() != 0; k++) tick();
        chk("drain_timeout", 32'(inj_q.size()), 0);
        tick(); tick();
        chk("fill_txc", 32'(tx_count), 8);

        // ejection into RX FIFO with overflow, then misroute
        ej_valid = 1; ej_data = 8'h81;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rx_q.push_back(8'h81);
            tick();
        end
        chk("ej_rxc", 32'(rx_count), 4);
        chk("ej_drop", 32'(drop_count), 1);
        ej_data = 8'h82;
        tick();
        ej_valid = 0;
        chk("misroute", 32'(misroute_count), 1);
        chk("misroute_rxc", 32'(rx_count), 4);
        chk("misroute_head", 32'(pe_rx_data), 32'h81);
        pe_rx_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        pe_rx_ready = 0;
        chk("rx_empty", 32'(pe_rx_valid), 0);

        // loopback yields to a concurrent ejection
        en_cycles = 0;
        pe_tx_data = 8'h25; pe_tx_valid = 1;
        tick();
        pe_tx_valid = 0;
        ej_valid = 1; ej_data = 8'h85;
        rx_q.push_back(8'h85); rx_q.push_back(8'h25);
        tick();
        ej_valid = 0;
        chk("lb_wait_rxc", 32'(rx_count), 5);
        chk("lb_wait_txc", 32'(tx_count), 8);
        tick();
        chk("lb_txc", 32'(tx_count), 9);
        chk("lb_rxc", 32'(rx_count), 6);
        chk("lb_head", 32'(pe_rx_data), 32'h85);
        pe_rx_ready = 1;
        tick(); tick();
        pe_rx_ready = 0;
        chk("lb_rx_empty", 32'(pe_rx_valid), 0);
        chk("lb_no_inject", 32'(en_cycles), 0);

        // asynchronous reset in the middle of an issue
        inj_stall = 1;
        pe_tx_data = 8'h43; pe_tx_valid = 1;
        ej_valid = 1; ej_data = 8'h81;
        tick();
        pe_tx_valid = 0; ej_valid = 0;
        tick();
        chk("pre_rst_en", 32'(inj_enable), 1);
        #2 rst = 0;
        #1;
        chk("async_en_drop", 32'(inj_enable), 0);
        chk("async_txc", 32'(tx_count), 0);
        chk("async_rx_valid", 32'(pe_rx_valid), 0);
        tick();
        rst = 1; inj_stall = 0;
        inj_q.delete(); rx_q.delete();
        tick(); tick(); tick();
        chk("post_rst_en", 32'(inj_enable), 0);
        chk("post_rst_counters", {tx_count, rx_count, drop_count, misroute_count}, 0);
        chk("post_rst_rx_valid", 32'(pe_rx_valid), 0);
        chk("post_rst_ready", 32'(pe_tx_ready), 1);
        chk("inj_q_left", 32'(inj_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
